// File: rtl/fifo_level_buf.sv
// fifo_level_buf: first-word fall-through FIFO with a level counter,
// registered empty/full/almost flags and sticky overflow/underflow flags.
// Optional build macro FIFO_RD_EDGE_EN: when defined, a pop happens only on
// the rising edge of rd, so a held rd removes exactly one word.
module fifo_level_buf #(
  parameter int B     = 8,
  parameter int W     = 4,
  parameter int AF_TH = 2**W - 2,
  parameter int AE_TH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic [B-1:0] w_data,
  input  logic         rd,
  input  logic         clr_err,
  output logic [B-1:0] r_data,
  output logic         empty,
  output logic         full,
  output logic         almost_empty,
  output logic         almost_full,
  output logic [W:0]   level,
  output logic         overflow,
  output logic         underflow
);

  localparam int         D          = 2**W;
  localparam logic [W:0] DEPTH_C    = (W+1)'(D);
  localparam logic [W:0] AF_TH_C    = (W+1)'(AF_TH);
  localparam logic [W:0] AE_TH_C    = (W+1)'(AE_TH);
  localparam logic [W:0] LVL_ZERO_C = (W+1)'(0);
  localparam logic [W-1:0] PTR_ZERO_C = W'(0);
  localparam logic [W-1:0] PTR_ONE_C  = W'(1);

  logic [B-1:0] mem_r [D];
  logic [W-1:0] w_ptr_r;
  logic [W-1:0] r_ptr_r;
  logic [W:0]   level_r;
  logic         empty_r;
  logic         full_r;
  logic         almost_empty_r;
  logic         almost_full_r;
  logic         overflow_r;
  logic         underflow_r;

  logic         pop_strobe_s;
  logic         push_acc_s;
  logic         pop_acc_s;
  logic         ovf_evt_s;
  logic         unf_evt_s;
  logic [W:0]   level_nxt_s;

`ifdef FIFO_RD_EDGE_EN
  logic rd_prev_r;

  // Remember last cycle's rd so only its rising edge requests a pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_prev_r <= 1'b0;
    end else begin
      rd_prev_r <= rd;
    end
  end

  // Pop strobe is the rising edge of rd.
  always_comb begin
    pop_strobe_s = rd & ~rd_prev_r;
  end
`else
  // Pop strobe follows rd level: one pop per cycle while rd is high.
  always_comb begin
    pop_strobe_s = rd;
  end
`endif

  // Accept/reject decisions use the registered flags; compute the next level.
  always_comb begin
    push_acc_s  = wr & ~full_r;
    pop_acc_s   = pop_strobe_s & ~empty_r;
    ovf_evt_s   = wr & full_r;
    unf_evt_s   = pop_strobe_s & empty_r;
    level_nxt_s = level_r + {{W{1'b0}}, push_acc_s} - {{W{1'b0}}, pop_acc_s};
  end

  // Storage array is not reset; a push coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (push_acc_s && !reset) begin
      mem_r[w_ptr_r] <= w_data;
    end
  end

  // Pointers, level and registered status flags, all updated on one edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr_r        <= PTR_ZERO_C;
      r_ptr_r        <= PTR_ZERO_C;
      level_r        <= LVL_ZERO_C;
      empty_r        <= 1'b1;
      full_r         <= 1'b0;
      almost_empty_r <= 1'b1;
      almost_full_r  <= 1'b0;
    end else begin
      if (push_acc_s) begin
        w_ptr_r <= w_ptr_r + PTR_ONE_C;
      end
      if (pop_acc_s) begin
        r_ptr_r <= r_ptr_r + PTR_ONE_C;
      end
      level_r        <= level_nxt_s;
      empty_r        <= (level_nxt_s == LVL_ZERO_C);
      full_r         <= (level_nxt_s == DEPTH_C);
      almost_empty_r <= (level_nxt_s <= AE_TH_C);
      almost_full_r  <= (level_nxt_s >= AF_TH_C);
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (clr_err) begin
      overflow_r  <= ovf_evt_s;
      underflow_r <= unf_evt_s;
    end else begin
      overflow_r  <= overflow_r | ovf_evt_s;
      underflow_r <= underflow_r | unf_evt_s;
    end
  end

  assign r_data       = mem_r[r_ptr_r];
  assign level        = level_r;
  assign empty        = empty_r;
  assign full         = full_r;
  assign almost_empty = almost_empty_r;
  assign almost_full  = almost_full_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

endmodule
